// File: rtl/argmax_stream_ctrl.sv
// Streaming argmax over NUM_CLASSES signed beats; result valid the cycle after the frame-end beat.
// Backpressure: in_ready drops while a result is held (min frame period NUM_CLASSES+1).
module argmax_stream_ctrl #(
    parameter int NUM_CLASSES = 10,
    parameter int DATA_W      = 32,
    parameter int IDX_W       = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [IDX_W-1:0]  out_index,
    output logic [DATA_W-1:0] out_value,
    output logic              frame_err,
    output logic              busy
);

    typedef enum logic {COLLECT, HOLD} state_t;

    localparam logic [IDX_W-1:0] LAST_CNT = IDX_W'(NUM_CLASSES - 1);

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   cnt;
    logic [IDX_W-1:0]   idx_q;
    logic [DATA_W-1:0]  max_q;

    logic               beat;
    logic               first;
    logic               greater;
    logic               at_last_cnt;
    logic               frame_end;
    logic [DATA_W-1:0]  upd_max;
    logic [IDX_W-1:0]   upd_idx;

    assign in_ready    = (state == COLLECT) && rst_n;
    assign out_valid   = (state == HOLD);
    assign busy        = (state == HOLD) || (cnt != '0);

    assign beat        = in_valid && in_ready;
    assign first       = (cnt == '0);
    assign greater     = $signed(in_data) > $signed(max_q);
    assign at_last_cnt = (cnt == LAST_CNT);
    assign frame_end   = beat && (at_last_cnt || in_last);

    // Strict compare keeps the lowest index on ties; beat 0 always seeds the running max.
    assign upd_max     = (first || greater) ? in_data : max_q;
    assign upd_idx     = first ? '0 : (greater ? cnt : idx_q);

    always_comb begin
        state_nxt = state;
        case (state)
            COLLECT: if (frame_end) state_nxt = HOLD;
            HOLD:    if (out_ready) state_nxt = COLLECT;
            default: state_nxt = COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= COLLECT;
            cnt       <= '0;
            idx_q     <= '0;
            max_q     <= '0;
            out_index <= '0;
            out_value <= '0;
            frame_err <= 1'b0;
        end else begin
            state <= state_nxt;
            if (frame_end) begin
                out_index <= upd_idx;
                out_value <= upd_max;
                // Error when in_last is missing on the final beat or arrives early.
                frame_err <= at_last_cnt ? !in_last : 1'b1;
                cnt       <= '0;
            end else if (beat) begin
                max_q <= upd_max;
                idx_q <= upd_idx;
                cnt   <= cnt + IDX_W'(1);
            end
        end
    end

endmodule
